cv32e40p_fpu_issue_sched: RTL and testbench

//  Issue scheduler for the shared FPU between the ID stage and the FPU datapath. It tracks
//  in-flight ops in the pipelined ADDMUL and OTHERS groups and the iterative DIVSQRT unit,
//  and prevents writeback-port collisions and RAW/WAW hazards on FP registers.
//  It drives the single FP register-file writeback port, one result per cycle.

---
 rtl/cv32e40p_fpu_issue_sched.sv | 165 ++++++++++++++++
 tb/tb_cv32e40p_fpu_issue_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_fpu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_fpu_issue_sched
// Description : Shared-FPU issue scheduler: writeback-slot reservation,
//               FP register scoreboard and iterative DIVSQRT tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_fpu_issue_sched #(
    parameter int FPU_ADDMUL_LAT = 2,
    parameter int FPU_OTHERS_LAT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        issue_valid_i,
    output logic        issue_ready_o,
    input  logic [1:0]  issue_grp_i,
    input  logic [4:0]  issue_rd_i,
    input  logic        issue_wb_i,
    input  logic [14:0] issue_rs_i,
    input  logic [2:0]  issue_rs_use_i,
    input  logic        divsqrt_done_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [1:0]  wb_grp_o,
    output logic        busy_o
);

    localparam int         c_maxlat       = (FPU_ADDMUL_LAT > FPU_OTHERS_LAT) ? FPU_ADDMUL_LAT : FPU_OTHERS_LAT;
    localparam logic [1:0] c_grp_addmul   = 2'd0;
    localparam logic [1:0] c_grp_others   = 2'd1;
    localparam logic [1:0] c_grp_divsqrt  = 2'd2;

    generate
        if (FPU_ADDMUL_LAT < 1 || FPU_ADDMUL_LAT > 4 ||
            FPU_OTHERS_LAT < 1 || FPU_OTHERS_LAT > 4) begin : g_bad_lat
            $fatal(1, "cv32e40p_fpu_issue_sched: latency parameters must be in 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_maxlat-1:0] r_s_valid;
    logic [c_maxlat-1:0] r_s_wb;
    logic [4:0]          r_s_rd  [c_maxlat];
    logic [1:0]          r_s_grp [c_maxlat];
    logic [31:0]         r_sb;
    logic [4:0]          r_ds_rd;
    logic                r_ds_wb;
    logic                r_en;

    logic [1:0]          w_grp;
    logic                w_is_ds;
    logic [2:0]          w_lat;
    logic                w_collide;
    logic                w_hazard;
    logic                w_fire;
    logic [31:0]         w_sb_set;
    logic [31:0]         w_sb_clr;

    // Reserved group code is treated as OTHERS everywhere, including wb_grp_o.
    assign w_grp   = (issue_grp_i == 2'd3) ? c_grp_others : issue_grp_i;
    assign w_is_ds = (w_grp == c_grp_divsqrt);
    assign w_lat   = (w_grp == c_grp_addmul) ? 3'(FPU_ADDMUL_LAT) : 3'(FPU_OTHERS_LAT);

    always_comb begin
        w_collide = 1'b0;
        for (int k = 0; k < c_maxlat; k++) begin
            if (w_lat == 3'(k)) begin
                w_collide = r_s_valid[k];
            end
        end
    end

    assign w_hazard = (issue_wb_i        & r_sb[issue_rd_i])
                    | (issue_rs_use_i[0] & r_sb[issue_rs_i[4:0]])
                    | (issue_rs_use_i[1] & r_sb[issue_rs_i[9:5]])
                    | (issue_rs_use_i[2] & r_sb[issue_rs_i[14:10]]);

    // r_en keeps ready low until the first clock edge after reset release.
    assign issue_ready_o = r_en & (r_state != S_PEND) & ~w_hazard
                         & (w_is_ds ? (r_state == S_IDLE) : ~w_collide);
    assign w_fire        = issue_valid_i & issue_ready_o;

    always_comb begin
        wb_valid_o = 1'b0;
        wb_rd_o    = 5'd0;
        wb_grp_o   = 2'd0;
        if (r_s_valid[0] && r_s_wb[0]) begin
            wb_valid_o = 1'b1;
            wb_rd_o    = r_s_rd[0];
            wb_grp_o   = r_s_grp[0];
        end else if ((r_state == S_PEND) && !r_s_valid[0] && r_ds_wb) begin
            wb_valid_o = 1'b1;
            wb_rd_o    = r_ds_rd;
            wb_grp_o   = c_grp_divsqrt;
        end
    end

    assign busy_o   = (|r_s_valid) | (r_state != S_IDLE);
    assign w_sb_set = (w_fire && issue_wb_i) ? (32'd1 << issue_rd_i) : 32'd0;
    assign w_sb_clr = wb_valid_o ? (32'd1 << wb_rd_o) : 32'd0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_fire && w_is_ds) w_state_nxt = S_BUSY;
            S_BUSY:  if (divsqrt_done_i)    w_state_nxt = S_PEND;
            S_PEND:  if (!r_s_valid[0])     w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_s_valid <= '0;
            r_s_wb    <= '0;
            for (int k = 0; k < c_maxlat; k++) begin
                r_s_rd[k]  <= 5'd0;
                r_s_grp[k] <= 2'd0;
            end
            r_sb      <= 32'd0;
            r_ds_rd   <= 5'd0;
            r_ds_wb   <= 1'b0;
            r_en      <= 1'b0;
        end else begin
            r_en    <= 1'b1;
            r_state <= w_state_nxt;
            for (int k = 0; k < c_maxlat - 1; k++) begin
                r_s_valid[k] <= r_s_valid[k+1];
                r_s_wb[k]    <= r_s_wb[k+1];
                r_s_rd[k]    <= r_s_rd[k+1];
                r_s_grp[k]   <= r_s_grp[k+1];
            end
            r_s_valid[c_maxlat-1] <= 1'b0;
            // A new pipelined op lands in the slot that drains to s[0] after exactly L cycles.
            if (w_fire && !w_is_ds) begin
                for (int k = 0; k < c_maxlat; k++) begin
                    if (w_lat == 3'(k + 1)) begin
                        r_s_valid[k] <= 1'b1;
                        r_s_wb[k]    <= issue_wb_i;
                        r_s_rd[k]    <= issue_rd_i;
                        r_s_grp[k]   <= w_grp;
                    end
                end
            end
            if (w_fire && w_is_ds) begin
                r_ds_rd <= issue_rd_i;
                r_ds_wb <= issue_wb_i;
            end
            r_sb <= (r_sb & ~w_sb_clr) | w_sb_set;
        end
    end

    a_done_only_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        divsqrt_done_i |-> (r_state == S_BUSY));

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_fpu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_fpu_issue_sched
// Description : Directed bench with an op-list reference model for LAT=2/2
//               and literal checks on a LAT=3/1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_fpu_issue_sched;

    localparam int A_LAT = 2;
    localparam int O_LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv, ir, iwb, done, wbv, busy;
    logic [1:0]  ig, wbgrp;
    logic [4:0]  ird, wbrd;
    logic [14:0] irs;
    logic [2:0]  iuse;

    logic        b_iv, b_ir, b_iwb, b_wbv, b_busy;
    logic [1:0]  b_ig, b_wbgrp;
    logic [4:0]  b_ird, b_wbrd;
    logic [14:0] b_irs;
    logic [2:0]  b_iuse;

    int checks   = 0;
    int failures = 0;

    cv32e40p_fpu_issue_sched #(.FPU_ADDMUL_LAT(A_LAT), .FPU_OTHERS_LAT(O_LAT)) u_dut (
        .clk_i(clk), .rst_i(rst), .issue_valid_i(iv), .issue_ready_o(ir),
        .issue_grp_i(ig), .issue_rd_i(ird), .issue_wb_i(iwb), .issue_rs_i(irs),
        .issue_rs_use_i(iuse), .divsqrt_done_i(done), .wb_valid_o(wbv),
        .wb_rd_o(wbrd), .wb_grp_o(wbgrp), .busy_o(busy)
    );

    cv32e40p_fpu_issue_sched #(.FPU_ADDMUL_LAT(3), .FPU_OTHERS_LAT(1)) u_dut31 (
        .clk_i(clk), .rst_i(rst), .issue_valid_i(b_iv), .issue_ready_o(b_ir),
        .issue_grp_i(b_ig), .issue_rd_i(b_ird), .issue_wb_i(b_iwb), .issue_rs_i(b_irs),
        .issue_rs_use_i(b_iuse), .divsqrt_done_i(1'b0), .wb_valid_o(b_wbv),
        .wb_rd_o(b_wbrd), .wb_grp_o(b_wbgrp), .busy_o(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight ops are kept with the absolute cycle of their writeback.
    typedef struct {
        int         wbc;
        logic [4:0] rd;
        logic [1:0] grp;
        logic       wb;
    } op_t;

    op_t        ops[$];
    logic [31:0] m_sb;
    bit         m_ds_act, m_ds_pend, m_ds_wb, m_en;
    logic [4:0] m_ds_rd;
    int         cyc = 0;

    always @(negedge clk) begin
        int         pi;
        bit         coll, hz, e_rdy, e_wbv, e_busy, fire;
        logic [4:0] e_rd;
        logic [1:0] e_grp, g;
        int         lat;
        op_t        nop;
        if (rst) begin
            chk("rst_ready", ir, 0);
            chk("rst_wbv", wbv, 0);
            chk("rst_wbrd", wbrd, 0);
            chk("rst_wbgrp", wbgrp, 0);
            chk("rst_busy", busy, 0);
            ops.delete();
            m_sb = 0; m_ds_act = 0; m_ds_pend = 0; m_ds_wb = 0; m_en = 0; m_ds_rd = 0;
        end else begin
            pi = -1;
            for (int i = 0; i < ops.size(); i++)
                if (ops[i].wbc == cyc) pi = i;
            e_wbv = 0; e_rd = 0; e_grp = 0;
            if (pi >= 0 && ops[pi].wb) begin
                e_wbv = 1; e_rd = ops[pi].rd; e_grp = ops[pi].grp;
            end else if (pi < 0 && m_ds_pend && m_ds_wb) begin
                e_wbv = 1; e_rd = m_ds_rd; e_grp = 2'd2;
            end
            g   = (ig == 2'd3) ? 2'd1 : ig;
            lat = (g == 2'd0) ? A_LAT : O_LAT;
            hz  = (iwb && m_sb[ird]) || (iuse[0] && m_sb[irs[4:0]]) ||
                  (iuse[1] && m_sb[irs[9:5]]) || (iuse[2] && m_sb[irs[14:10]]);
            coll = 0;
            for (int i = 0; i < ops.size(); i++)
                if (ops[i].wbc == cyc + lat) coll = 1;
            if (!m_en || m_ds_pend || hz) e_rdy = 0;
            else if (g == 2'd2)           e_rdy = !m_ds_act;
            else                          e_rdy = !coll;
            e_busy = (ops.size() > 0) || m_ds_act || m_ds_pend;
            if (m_en) chk("model_ready", ir, e_rdy);
            chk("model_wbv", wbv, e_wbv);
            chk("model_wbrd", wbrd, e_rd);
            chk("model_wbgrp", wbgrp, e_grp);
            chk("model_busy", busy, e_busy);

            fire = iv && e_rdy;
            if (e_wbv) m_sb[e_rd] = 1'b0;
            if (fire && iwb) m_sb[ird] = 1'b1;
            if (pi >= 0) ops.delete(pi);
            if (fire && g != 2'd2) begin
                nop.wbc = cyc + lat; nop.rd = ird; nop.grp = g; nop.wb = iwb;
                ops.push_back(nop);
            end
            if (m_ds_pend && pi < 0) m_ds_pend = 0;
            if (m_ds_act && done) begin m_ds_act = 0; m_ds_pend = 1; end
            if (fire && g == 2'd2) begin m_ds_act = 1; m_ds_rd = ird; m_ds_wb = iwb; end
            m_en = 1;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [1:0] g, input logic [4:0] rd, input logic wb,
                       input logic [14:0] rs, input logic [2:0] u);
        iv = v; ig = g; ird = rd; iwb = wb; irs = rs; iuse = u;
    endtask

    task automatic bput(input logic v, input logic [1:0] g, input logic [4:0] rd, input logic wb);
        b_iv = v; b_ig = g; b_ird = rd; b_iwb = wb; b_irs = 15'd0; b_iuse = 3'd0;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            put(0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        rst = 1'b1; done = 1'b0;
        put(1, 0, 5'd2, 1, 0, 0);
        bput(0, 0, 0, 0);
        idle_n(3);
        tick(); rst = 1'b0; put(0, 0, 0, 0, 0, 0);

        // ADDMUL rd=3: wb at t=2 only, no bypass at t=2, scoreboard clear at t=3
        for (int t = 0; t < 4; t++) begin
            tick();
            case (t)
                0: put(1, 0, 5'd3, 1, 0, 0);
                1: put(0, 0, 0, 0, 0, 0);
                default: put(0, 0, 5'd9, 1, {5'd3, 5'd0, 5'd0}, 3'b100);
            endcase
            #2;
            case (t)
                0: chk("t1_ready_t0", ir, 1);
                1: chk("t1_wbv_t1", wbv, 0);
                2: begin chk("t1_wbv_t2", wbv, 1); chk("t1_wbrd_t2", wbrd, 3); chk("t1_nobypass", ir, 0); end
                default: begin chk("t1_wbv_t3", wbv, 0); chk("t1_sbclear_t3", ir, 1); end
            endcase
        end
        idle_n(2);

        // RAW on rd=5 via rs1
        for (int t = 0; t < 4; t++) begin
            tick();
            if (t == 0) put(1, 0, 5'd5, 1, 0, 0);
            else        put(1, 0, 5'd6, 1, {5'd0, 5'd0, 5'd5}, 3'b001);
            #2;
            chk("t3_ready", ir, (t == 0 || t == 3) ? 1 : 0);
        end
        idle_n(5);

        // back-to-back ADDMUL rd=1..8
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k < 8) put(1, 0, 5'(k + 1), 1, 0, 0);
            else       put(0, 0, 0, 0, 0, 0);
            #2;
            if (k < 8) chk("t6_ready", ir, 1);
            if (k >= 2) begin chk("t6_wbv", wbv, 1); chk("t6_wbrd", wbrd, k - 1); end
        end
        idle_n(3);

        // DIVSQRT rd=7 with a pipelined writeback colliding with the pending result
        for (int t = 0; t < 14; t++) begin
            tick();
            done = (t == 10);
            case (t)
                0:  put(1, 2, 5'd7, 1, 0, 0);
                5:  put(1, 2, 5'd8, 1, 0, 0);
                6:  put(1, 0, 5'd12, 1, {5'd0, 5'd0, 5'd7}, 3'b001);
                9:  put(1, 0, 5'd9, 1, 0, 0);
                11, 12, 13: put(1, 0, 5'd11, 1, {5'd0, 5'd0, 5'd7}, 3'b001);
                default: put(0, 0, 0, 0, 0, 0);
            endcase
            #2;
            case (t)
                0:  chk("t4_ds_ready", ir, 1);
                5:  chk("t4_ds_blocked", ir, 0);
                6:  chk("t4_raw_rd7", ir, 0);
                9:  chk("t4_busy_add", ir, 1);
                10: chk("t4_busy", busy, 1);
                11: begin chk("t4_pend_ready11", ir, 0); chk("t4_wbrd11", wbrd, 9); chk("t4_wbgrp11", wbgrp, 0); end
                12: begin chk("t4_pend_ready12", ir, 0); chk("t4_wbv12", wbv, 1);
                          chk("t4_wbrd12", wbrd, 7); chk("t4_wbgrp12", wbgrp, 2); end
                13: begin chk("t4_ready13", ir, 1); chk("t4_wbv13", wbv, 0); end
                default: ;
            endcase
        end
        idle_n(4);

        // reset with two ADDMUL ops and one DIVSQRT in flight
        for (int t = 0; t < 13; t++) begin
            tick();
            done = (t == 10);
            if (t == 3) rst = 1'b1;
            if (t == 5) rst = 1'b0;
            case (t)
                0: put(1, 2, 5'd20, 1, 0, 0);
                1: put(1, 0, 5'd21, 1, 0, 0);
                2: put(1, 0, 5'd22, 1, 0, 0);
                6: put(1, 2, 5'd20, 1, {5'd22, 5'd21, 5'd20}, 3'b111);
                default: put(0, 0, 0, 0, 0, 0);
            endcase
            #2;
            case (t)
                3: begin chk("t5_wbv_rst", wbv, 0); chk("t5_busy_rst", busy, 0); end
                6: begin chk("t5_ds_ready", ir, 1); chk("t5_busy6", busy, 0); chk("t5_wbv6", wbv, 0); end
                7, 8, 9: chk("t5_nowb", wbv, 0);
                11: begin chk("t5_wbv11", wbv, 1); chk("t5_wbrd11", wbrd, 20); chk("t5_wbgrp11", wbgrp, 2); end
                12: chk("t5_busy12", busy, 0);
                default: ;
            endcase
        end
        idle_n(2);

        // LAT=3/1 instance: collision, reserved group, wb=0 slot occupancy
        for (int t = 0; t < 10; t++) begin
            tick();
            case (t)
                0:    bput(1, 0, 5'd1, 1);
                2, 3: bput(1, 1, 5'd2, 1);
                4:    bput(1, 3, 5'd4, 1);
                5:    bput(1, 0, 5'd5, 0);
                7, 8: bput(1, 1, 5'd6, 1);
                default: bput(0, 0, 0, 0);
            endcase
            #2;
            case (t)
                0: chk("t2_ready0", b_ir, 1);
                2: chk("t2_blocked2", b_ir, 0);
                3: begin chk("t2_ready3", b_ir, 1); chk("t2_wbv3", b_wbv, 1);
                         chk("t2_wbrd3", b_wbrd, 1); chk("t2_wbgrp3", b_wbgrp, 0); end
                4: begin chk("t2_ready4", b_ir, 1); chk("t2_wbrd4", b_wbrd, 2); chk("t2_wbgrp4", b_wbgrp, 1); end
                5: begin chk("t2_wbrd5", b_wbrd, 4); chk("t2_wbgrp5", b_wbgrp, 1); end
                7: chk("t2_nowb_slot_block", b_ir, 0);
                8: begin chk("t2_ready8", b_ir, 1); chk("t2_wbv8", b_wbv, 0); chk("t2_busy8", b_busy, 1); end
                9: begin chk("t2_wbv9", b_wbv, 1); chk("t2_wbrd9", b_wbrd, 6); end
                default: ;
            endcase
        end
        idle_n(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
